// File: rtl/letter_disp_pkg.sv
// letter_disp_pkg: shared letter-code constants, scroll FSM states and input code sanitising.
package letter_disp_pkg;
  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd0;
  localparam logic [CODE_W-1:0] CODE_MAX = 5'd26;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;
  function automatic logic [CODE_W-1:0] sanitize_code(input logic [CODE_W-1:0] c);
    return (c > CODE_MAX) ? CODE_BLANK : c;
  endfunction
endpackage

// File: rtl/letter_fifo.sv
// letter_fifo: synchronous letter FIFO with flush; count tells full from empty since pointers wrap.
module letter_fifo import letter_disp_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  logic [CODE_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/letter_scroll_ctrl.sv
// letter_scroll_ctrl: scrolls buffered Morse letters right-to-left across a seven-segment bank.
// Optional LSC_BLANK_FLUSH_EN: once the FIFO drains, blanks are shifted in until the display is empty.
module letter_scroll_ctrl import letter_disp_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [CODE_W-1:0]              in_letter,
  output logic                           in_ready,
  input  logic                           clear,
  output logic [CODE_W*NUM_DIGITS-1:0]   digit_codes,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                           overflow,
  output logic                           busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TICK_DIV);
  state_t state, next_state;
  logic [TW-1:0] timer;
  logic full, empty, push, pop, shift, flush_more;
  logic [CODE_W-1:0] head;
  assign in_ready = !full;
  assign push = in_valid && in_ready && !clear;
  letter_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push(push),
    .pop(pop && !clear),
    .din(sanitize_code(in_letter)),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
`ifdef LSC_BLANK_FLUSH_EN
  assign flush_more = |digit_codes;
`else
  assign flush_more = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= clear ? IDLE : next_state;
  end
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = empty ? IDLE : SHIFT;
    else if (state == SHIFT) next_state = WAIT;
    else if (timer == '0) next_state = (!empty || flush_more) ? SHIFT : IDLE;
  end
  always_comb begin
    shift = state == SHIFT;
    pop = shift && !empty;
    busy = state != IDLE;
  end
  // In flush mode a SHIFT with an empty FIFO feeds a blank instead of popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      digit_codes <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      timer <= '0;
      digit_codes <= '0;
      overflow <= 1'b0;
    end else begin
      timer <= (state == IDLE) ? '0 :
               shift ? TW'(TICK_DIV - 1) :
               (timer != '0) ? timer - 1'b1 : timer;
      digit_codes <= shift ? {digit_codes[CODE_W*(NUM_DIGITS-1)-1:0], pop ? head : CODE_BLANK}
                           : digit_codes;
      overflow <= overflow || (in_valid && !in_ready);
    end
  end
endmodule

// File: tb/tb_letter_scroll_ctrl.sv
// tb_letter_scroll_ctrl: directed checks of the letter scroll controller (4 digits, 4-deep FIFO, tick 4).
module tb_letter_scroll_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [4:0] in_letter = '0;
  logic in_ready;
  logic clear = 1'b0;
  logic [19:0] digit_codes;
  logic [2:0] fifo_count;
  logic overflow;
  logic busy;
  int tests = 0;
  int fails = 0;

  letter_scroll_ctrl #(.NUM_DIGITS(4), .FIFO_DEPTH(4), .TICK_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_letter(in_letter),
    .in_ready(in_ready),
    .clear(clear),
    .digit_codes(digit_codes),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [4:0] l);
    in_valid = 1'b1;
    in_letter = l;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (digit_codes !== 20'h0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_init got digits=%h count=%0d ready=%b busy=%b ovf=%b exp 0/0/1/0/0", digit_codes, fifo_count, in_ready, busy, overflow);
      fails++;
    end
    #10 rst_n = 1'b1;
    step(1);
    push(5'd1);
    push(5'd2);
    push(5'd3);
    step(1);
    tests++;
    if (busy !== 1'b1 || fifo_count !== 3'd2 || digit_codes !== 20'd1) begin
      $display("FAIL reset_pre got busy=%b count=%0d digits=%h exp 1/2/00001", busy, fifo_count, digit_codes);
      fails++;
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (digit_codes !== 20'h0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_mid got digits=%h count=%0d ready=%b busy=%b exp 0/0/1/0", digit_codes, fifo_count, in_ready, busy);
      fails++;
    end
    #1 rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_scroll();
    push(5'd8);
    push(5'd9);
    step(1);
    tests++;
    if (digit_codes !== 20'h00008) begin
      $display("FAIL scroll_first got %h exp 00008", digit_codes);
      fails++;
    end
    step(5);
    tests++;
    if (digit_codes !== 20'h00109) begin
      $display("FAIL scroll_second got %h exp 00109", digit_codes);
      fails++;
    end
    step(4);
`ifndef LSC_BLANK_FLUSH_EN
    tests++;
    if (busy !== 1'b0 || digit_codes !== 20'h00109) begin
      $display("FAIL scroll_idle got busy=%b digits=%h exp 0/00109", busy, digit_codes);
      fails++;
    end
`endif
    do_clear();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_letter = 5'd1;
    step(1);
    tests++;
    if (fifo_count !== 3'd1) begin
      $display("FAIL b2b_count1 got %0d exp 1", fifo_count);
      fails++;
    end
    in_letter = 5'd2;
    step(1);
    in_letter = 5'd3;
    step(1);
    tests++;
    if (fifo_count !== 3'd2 || digit_codes !== 20'h00001) begin
      $display("FAIL b2b_pop got count=%0d digits=%h exp 2/00001", fifo_count, digit_codes);
      fails++;
    end
    in_letter = 5'd4;
    step(1);
    in_letter = 5'd5;
    step(1);
    tests++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL b2b_full got count=%0d ready=%b ovf=%b exp 4/0/0", fifo_count, in_ready, overflow);
      fails++;
    end
    in_letter = 5'd6;
    step(1);
    in_valid = 1'b0;
    tests++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      $display("FAIL b2b_overflow got ovf=%b count=%0d exp 1/4", overflow, fifo_count);
      fails++;
    end
    do_clear();
  endtask

  task automatic test_sanitize();
    push(5'd30);
    step(2);
    tests++;
    if (digit_codes !== 20'h0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
      $display("FAIL sanitize_30 got digits=%h busy=%b count=%0d exp 00000/1/0", digit_codes, busy, fifo_count);
      fails++;
    end
    push(5'd26);
    step(4);
    tests++;
    if (digit_codes !== 20'h0001a) begin
      $display("FAIL sanitize_26 got %h exp 0001a", digit_codes);
      fails++;
    end
    do_clear();
  endtask

  task automatic test_clear();
    in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_letter = 5'(i);
      step(1);
    end
    in_valid = 1'b0;
    step(2);
    tests++;
    if (fifo_count !== 3'd3 || busy !== 1'b1 || overflow !== 1'b1 || digit_codes !== 20'h00022) begin
      $display("FAIL clear_pre got count=%0d busy=%b ovf=%b digits=%h exp 3/1/1/00022", fifo_count, busy, overflow, digit_codes);
      fails++;
    end
    in_valid = 1'b1;
    in_letter = 5'd7;
    do_clear();
    in_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd0 || digit_codes !== 20'h0 || overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL clear_post got count=%0d digits=%h ovf=%b busy=%b ready=%b exp 0/00000/0/0/1", fifo_count, digit_codes, overflow, busy, in_ready);
      fails++;
    end
  endtask

  task automatic test_flush();
    push(5'd1);
    push(5'd2);
    step(1);
    tests++;
    if (digit_codes !== 20'h00001) begin
      $display("FAIL flush_a got %h exp 00001", digit_codes);
      fails++;
    end
    step(5);
    tests++;
    if (digit_codes !== 20'h00022) begin
      $display("FAIL flush_ab got %h exp 00022", digit_codes);
      fails++;
    end
    step(4);
`ifdef LSC_BLANK_FLUSH_EN
    step(1);
    tests++;
    if (digit_codes !== 20'h00440 || busy !== 1'b1) begin
      $display("FAIL flush_blank1 got digits=%h busy=%b exp 00440/1", digit_codes, busy);
      fails++;
    end
    step(15);
    tests++;
    if (digit_codes !== 20'h0) begin
      $display("FAIL flush_empty got %h exp 00000", digit_codes);
      fails++;
    end
    step(4);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL flush_idle got busy=%b exp 0", busy);
      fails++;
    end
`else
    tests++;
    if (busy !== 1'b0 || digit_codes !== 20'h00022) begin
      $display("FAIL hold_idle got busy=%b digits=%h exp 0/00022", busy, digit_codes);
      fails++;
    end
    step(20);
    tests++;
    if (busy !== 1'b0 || digit_codes !== 20'h00022) begin
      $display("FAIL hold_later got busy=%b digits=%h exp 0/00022", busy, digit_codes);
      fails++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_back_to_back();
    test_sanitize();
    test_clear();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
